mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
Sequential accumulate stage directly downstream of the 8x8 Wallace multiplier. It consumes the 16-bit product stream over a valid/ready handshake and sums LEN consecutive products into a wide accumulator. It then presents the dot-product result on an output valid/ready handshake. Products are treated as unsigned. No rounding or saturation is applied; a sticky flag reports overflow.

Parameters:
PROD_W, 16, product width; matches the multiplier output z.
ACC_W, 24, accumulator and result width; must be >= PROD_W.
LEN, 4, products per accumulation; legal range 1..255.
CNT_W, 8, width of the product counter; must satisfy 2^CNT_W > LEN.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  reset; one clock, synchronous, active-high.
start  in  1  begin a new accumulation; sampled only in IDLE.
prod_valid  in  1  prod carries a valid product this cycle.
prod  in  PROD_W  product from the multiplier (z).
prod_ready  out  1  block accepts prod this cycle.
acc_valid  out  1  acc_out holds a completed result.
acc_out  out  ACC_W  accumulated sum.
acc_ready  in  1  downstream accepts acc_out.
busy  out  1  high in ACCUM or DONE.
overflow  out  1  sticky; a carry out of ACC_W occurred in the current accumulation.

Behaviour:
- Reset, when rst=1 at the clock edge:
  - state goes to IDLE; the accumulator and counter are cleared to 0.
  - Outputs are then prod_ready=0, acc_valid=0, acc_out=0, busy=0, overflow=0.
  - rst overrides every other input in any state, including mid-accumulation and while DONE is waiting. Any partial sum is discarded.
- Handshakes:
  - A product transfer occurs on a cycle where prod_valid=1 and prod_ready=1.
  - A result transfer occurs on a cycle where acc_valid=1 and acc_ready=1.
  - prod_ready is a pure function of state: 1 only in ACCUM. It does not depend on prod_valid.
- State machine: IDLE, ACCUM, DONE (registered state).
  - IDLE: prod_ready=0, acc_valid=0, busy=0. acc_out keeps the last result.
    - start=1: clear the accumulator, counter and overflow to 0; go to ACCUM next cycle.
    - prod_valid is ignored in IDLE.
  - ACCUM: prod_ready=1, busy=1.
    - On each product transfer: acc <= (acc + prod) mod 2^ACC_W; cnt <= cnt + 1.
    - If that addition carries out of ACC_W, overflow <= 1. Once set, overflow stays 1 until the next start or rst.
    - Cycles with prod_valid=0 leave all state unchanged; bubbles are allowed.
    - When the transfer that makes cnt reach LEN occurs (cnt == LEN-1 before the edge), go to DONE. That last product is included in the sum.
  - DONE: acc_valid=1, prod_ready=0, busy=1. acc_out equals the final sum and is held stable until transfer.
    - On a result transfer: go to IDLE. acc_out keeps its value; acc_valid drops next cycle.
- start is ignored in ACCUM and DONE.
- A start asserted in the same cycle as the DONE result transfer is also ignored. The block re-arms only after reaching IDLE, so the minimum gap is one IDLE cycle.
- Latency:
  - First product may be accepted 1 cycle after start is sampled.
  - acc_valid rises 1 cycle after the LEN-th product transfer.
  - With continuous prod_valid=1, LEN products take LEN cycles in ACCUM. The result appears at cycle LEN+1 after the start edge.
- LEN=1: ACCUM accepts exactly one product, then DONE. In that case acc_out = zero-extended prod.
- Width rules:
  - prod is zero-extended to ACC_W before the addition.
  - overflow is the carry out of bit ACC_W-1. No saturation is applied.
- acc_out is registered; there are no combinational paths from prod or prod_valid to acc_out.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with prod_valid=1 and start=0 -> prod_ready=0, acc_valid=0, acc_out=0, busy=0, overflow=0 throughout.
- Basic sum, LEN=4, ACC_W=24: start, then products 15, 14, 21, 0 back-to-back -> acc_valid high on the cycle after the 4th transfer, acc_out=50, overflow=0. With acc_ready held 0 for 3 cycles, acc_out stays 50 and prod_ready stays 0.
- Bubbles and ignored start: same four products with prod_valid toggling 1,0,1,0,... and start pulsed during ACCUM -> acc_out=50. Exactly 4 transfers are counted and no restart occurs.
- Overflow, ACC_W=17, LEN=4: four products of 65025 -> acc_out=129028 and overflow=1. The next start clears overflow; sum 1+1+1+1 then gives acc_out=4 with overflow=0.
- Reset mid-operation: rst asserted after 2 of 4 products (values 100, 200) -> IDLE with acc_out=0. A new start plus 3, 3, 3, 3 gives acc_out=12 with no residue of 300.
- LEN=1: start, then product 65535 -> acc_valid one cycle after the transfer, acc_out=65535. A start in the transfer cycle is ignored; a start one cycle later is accepted.

Source files
------------

// File: rtl/mac_accumulator_if.sv
// Product-in / result-out handshake bundle for the accumulate stage.
// The slave side is the accumulator; the master side feeds and drains it.
interface mac_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              start;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              acc_valid;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_ready;
  logic              busy;
  logic              overflow;

  modport slave (
    input  start,
    input  prod_valid,
    input  prod,
    output prod_ready,
    output acc_valid,
    output acc_out,
    input  acc_ready,
    output busy,
    output overflow
  );

  modport master (
    output start,
    output prod_valid,
    output prod,
    input  prod_ready,
    input  acc_valid,
    input  acc_out,
    output acc_ready,
    input  busy,
    input  overflow
  );
endinterface

// File: rtl/mac_accumulator.sv
// Sums LEN unsigned products into an ACC_W accumulator and
// hands the dot product downstream; sticky carry-out flag.
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_accumulator_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // Extra top bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(io.prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (io.prod_valid) begin
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (sum[ACC_W])
            ovf_d = 1'b1;
          if (cnt_q == LAST)
            state_d = DONE;
        end
      end
      DONE: begin
        if (io.acc_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.prod_ready = (state_q == ACCUM);
  assign io.acc_valid  = (state_q == DONE);
  assign io.busy       = (state_q != IDLE);
  assign io.acc_out    = acc_q;
  assign io.overflow   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (24b/LEN4, 17b/LEN4,
// 24b/LEN1), table vectors, corner sequences and a random model.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  start_v, pv_v, ar_v;
  logic [15:0] pd_v [3];
  logic [2:0]  pr_v, av_v, busy_v, ov_v;
  logic [23:0] ao_v [3];

  int nvec = 0;
  int nerr = 0;

  mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) ia ();
  mac_accumulator_if #(.PROD_W(16), .ACC_W(17)) ib ();
  mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) ic ();

  mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(4), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .io(ia));
  mac_accumulator #(.PROD_W(16), .ACC_W(17), .LEN(4), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst), .io(ib));
  mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(1), .CNT_W(8))
    dut_c (.clk(clk), .rst(rst), .io(ic));

  assign ia.start      = start_v[0];
  assign ia.prod_valid = pv_v[0];
  assign ia.prod       = pd_v[0];
  assign ia.acc_ready  = ar_v[0];
  assign ib.start      = start_v[1];
  assign ib.prod_valid = pv_v[1];
  assign ib.prod       = pd_v[1];
  assign ib.acc_ready  = ar_v[1];
  assign ic.start      = start_v[2];
  assign ic.prod_valid = pv_v[2];
  assign ic.prod       = pd_v[2];
  assign ic.acc_ready  = ar_v[2];

  assign pr_v   = {ic.prod_ready, ib.prod_ready, ia.prod_ready};
  assign av_v   = {ic.acc_valid, ib.acc_valid, ia.acc_valid};
  assign busy_v = {ic.busy, ib.busy, ia.busy};
  assign ov_v   = {ic.overflow, ib.overflow, ia.overflow};
  assign ao_v[0] = ia.acc_out;
  assign ao_v[1] = 24'(ib.acc_out);
  assign ao_v[2] = ic.acc_out;

  typedef struct {
    logic [15:0] p [4];
    logic [23:0] sum;
    bit          ov;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_outs(input int k, input string nm,
                           input logic [23:0] ao);
    chk({nm, "_prdy"}, 32'(pr_v[k]), 0);
    chk({nm, "_aval"}, 32'(av_v[k]), 0);
    chk({nm, "_busy"}, 32'(busy_v[k]), 0);
    chk({nm, "_ao"}, 32'(ao_v[k]), 32'(ao));
  endtask

  // One full accumulation on instance k; bub adds bubbles and
  // stray start pulses while accumulating.
  task automatic run(input int k, input logic [15:0] p [$],
                     input bit bub, input int hold,
                     input logic [23:0] exp, input bit eov,
                     input string nm);
    int to;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk({nm, "_busy_go"}, 32'(busy_v[k]), 1);
    for (int i = 0; i < p.size(); i++) begin
      if (bub && ($urandom_range(1, 0) == 1 || i == 0)) begin
        pv_v[k] = 1'b0;
        start_v[k] = 1'b1;
        @(negedge clk);
      end
      start_v[k] = bub;
      pv_v[k] = 1'b1;
      pd_v[k] = p[i];
      to = 0;
      while (!pr_v[k] && to < 10) begin
        @(negedge clk);
        to++;
      end
      if (to >= 10)
        chk({nm, "_prdy_timeout"}, 0, 1);
      @(negedge clk);
      pv_v[k] = 1'b0;
      start_v[k] = 1'b0;
    end
    chk({nm, "_aval_lat"}, 32'(av_v[k]), 1);
    to = 0;
    while (!av_v[k] && to < 10) begin
      @(negedge clk);
      to++;
    end
    chk({nm, "_ao"}, 32'(ao_v[k]), 32'(exp));
    chk({nm, "_ovf"}, 32'(ov_v[k]), 32'(eov));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_ao"}, 32'(ao_v[k]), 32'(exp));
      chk({nm, "_hold_prdy"}, 32'(pr_v[k]), 0);
      chk({nm, "_hold_aval"}, 32'(av_v[k]), 1);
    end
    ar_v[k] = 1'b1;
    @(negedge clk);
    ar_v[k] = 1'b0;
    idle_outs(k, {nm, "_after"}, exp);
  endtask

  logic [15:0] q [$];
  longint      tot;
  int          w;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].p = '{16'd15, 16'd14, 16'd21, 16'd0};
    tbl[0].sum = 24'd50;     tbl[0].ov = 1'b0;
    tbl[1].p = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1].sum = 24'd262140; tbl[1].ov = 1'b0;
    tbl[2].p = '{16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].sum = 24'd0;      tbl[2].ov = 1'b0;
    tbl[3].p = '{16'hFFFF, 16'd1, 16'd0, 16'd7};
    tbl[3].sum = 24'd65543;  tbl[3].ov = 1'b0;

    start_v = '0; ar_v = '0;
    pv_v = 3'b111;
    for (int k = 0; k < 3; k++) pd_v[k] = 16'h1234;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        idle_outs(k, "rst", 24'd0);
        chk("rst_ovf", 32'(ov_v[k]), 0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    idle_outs(0, "idle_pv", 24'd0);
    pv_v = '0;

    for (int t = 0; t < 4; t++) begin
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(tbl[t].p[i]);
      run(0, q, 1'b0, (t == 0) ? 3 : 0, tbl[t].sum, tbl[t].ov,
          $sformatf("tbl%0d", t));
    end

    q = {16'd15, 16'd14, 16'd21, 16'd0};
    run(0, q, 1'b1, 0, 24'd50, 1'b0, "bubble");

    q = {16'd65025, 16'd65025, 16'd65025, 16'd65025};
    run(1, q, 1'b0, 1, 24'd129028, 1'b1, "ovf17");
    chk("ovf17_sticky_idle", 32'(ov_v[1]), 1);
    q = {16'd1, 16'd1, 16'd1, 16'd1};
    run(1, q, 1'b0, 0, 24'd4, 1'b0, "ovf17_clr");

    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    pv_v[0] = 1'b1; pd_v[0] = 16'd100;
    @(negedge clk);
    pd_v[0] = 16'd200;
    @(negedge clk);
    pv_v[0] = 1'b0;
    chk("mid_partial", 32'(ao_v[0]), 300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_outs(0, "mid_rst", 24'd0);
    chk("mid_rst_ovf", 32'(ov_v[0]), 0);
    q = {16'd3, 16'd3, 16'd3, 16'd3};
    run(0, q, 1'b0, 0, 24'd12, 1'b0, "mid_new");

    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    chk("len1_prdy", 32'(pr_v[2]), 1);
    pv_v[2] = 1'b1; pd_v[2] = 16'hFFFF;
    @(negedge clk);
    pv_v[2] = 1'b0;
    chk("len1_aval", 32'(av_v[2]), 1);
    chk("len1_ao", 32'(ao_v[2]), 65535);
    ar_v[2] = 1'b1; start_v[2] = 1'b1;
    @(negedge clk);
    ar_v[2] = 1'b0;
    chk("len1_start_ign", 32'(busy_v[2]), 0);
    chk("len1_aval_drop", 32'(av_v[2]), 0);
    @(negedge clk);
    start_v[2] = 1'b0;
    chk("len1_rearm_busy", 32'(busy_v[2]), 1);
    chk("len1_rearm_prdy", 32'(pr_v[2]), 1);
    pv_v[2] = 1'b1; pd_v[2] = 16'd7;
    @(negedge clk);
    pv_v[2] = 1'b0;
    chk("len1_ao2", 32'(ao_v[2]), 7);
    ar_v[2] = 1'b1;
    @(negedge clk);
    ar_v[2] = 1'b0;
    chk("len1_done", 32'(busy_v[2]), 0);

    // Reference: exact integer total; wrapped result and whether
    // the total ever reached 2^W.
    for (int r = 0; r < 40; r++) begin
      int k;
      k = r % 2;
      w = (k == 0) ? 24 : 17;
      q = {};
      tot = 0;
      for (int i = 0; i < 4; i++) begin
        logic [15:0] v;
        v = ($urandom_range(1, 0) == 1) ? 16'(65535 - $urandom_range(2000, 0))
                                        : 16'($urandom_range(65535, 0));
        q.push_back(v);
        tot += longint'(v);
      end
      run(k, q, $urandom_range(1, 0) == 1, $urandom_range(2, 0),
          24'(tot % (64'd1 << w)), tot >= (64'd1 << w),
          $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
